bmp_cmd_queue: RTL and testbench

- Memory-mapped command front end that sits directly upstream of the BMP display engine.
- Captures CPU writes to the BMP register window (0xC008–0xC00B), assembles each draw request into one command word and buffers it in a small FIFO.
- Presents commands to the display engine over a valid/ready handshake, so back-to-back CPU draw requests are not lost while the engine is busy blitting.
- Exposes a status/control register at 0xC00B, read and written by the CPU.

---
 rtl/bmp_pkg.sv | 25 ++
 rtl/bmp_cmd_fifo.sv | 72 +++++++
 rtl/bmp_cmd_queue.sv | 102 ++++++++++
 tb/tb_bmp_cmd_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP command path: register window addresses,
// command field widths, the command word layout and status bit positions.
package bmp_pkg;

  localparam logic [15:0] BMP_XLOC_ADDR = 16'hC008;
  localparam logic [15:0] BMP_YLOC_ADDR = 16'hC009;
  localparam logic [15:0] BMP_CMD_ADDR  = 16'hC00A;
  localparam logic [15:0] BMP_STAT_ADDR = 16'hC00B;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int IW = 6;

  // One draw request as consumed by the display engine.
  typedef struct packed {
    logic [XW-1:0] xloc;
    logic [YW-1:0] yloc;
    logic [IW-1:0] img;
  } bmp_cmd_t;

  localparam int STAT_OVF_BIT   = 15;
  localparam int STAT_FULL_BIT  = 14;
  localparam int STAT_EMPTY_BIT = 13;

endpackage

// File: rtl/bmp_cmd_fifo.sv
// First-word-fall-through command FIFO. The head entry is visible on dout_o
// whenever the FIFO is non-empty; a push into an empty FIFO shows up one
// cycle later (no bypass). Flush overrides push and pop.
module bmp_cmd_fifo
  import bmp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  bmp_cmd_t         din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output bmp_cmd_t         dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  bmp_cmd_t         mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  // Hold the outputs at zero while nothing is valid so reset shows all-zero.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers/count; a push while full is only taken if a pop frees a slot.
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bmp_cmd_queue.sv
// CPU-facing front end for the BMP display engine: decodes the 0xC008-0xC00B
// window, stages X/Y, queues one command per 0xC00A write and exposes a
// status/control register at 0xC00B.
module bmp_cmd_queue
  import bmp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mm_we,
  input  logic        mm_re,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_hit,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_xloc,
  output logic [8:0]  cmd_yloc,
  output logic [5:0]  cmd_img
);

  logic [XW-1:0]    xloc_stg_q;
  logic [YW-1:0]    yloc_stg_q;
  logic             overflow_q, overflow_d;
  logic             xloc_we, yloc_we, cmd_push, flush, pop, drop;
  bmp_cmd_t         fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_wdata;

  assign xloc_we  = mm_we & (addr == BMP_XLOC_ADDR);
  assign yloc_we  = mm_we & (addr == BMP_YLOC_ADDR);
  assign cmd_push = mm_we & (addr == BMP_CMD_ADDR);
  assign flush    = mm_we & (addr == BMP_STAT_ADDR) & wdata[0];
  assign rd_hit   = mm_re & (addr == BMP_STAT_ADDR);
  assign pop      = cmd_valid & cmd_ready;
  assign drop     = cmd_push & fifo_full & ~pop;

  assign fifo_din     = {xloc_stg_q, yloc_stg_q, wdata[IW-1:0]};
  assign unused_wdata = ^wdata[15:XW];

  bmp_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .flush_i (flush),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd_xloc  = fifo_dout.xloc;
  assign cmd_yloc  = fifo_dout.yloc;
  assign cmd_img   = fifo_dout.img;

  // X/Y staging; values persist so repeated pushes reuse the last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xloc_stg_q <= '0;
      yloc_stg_q <= '0;
    end else begin
      if (xloc_we) xloc_stg_q <= wdata[XW-1:0];
      if (yloc_we) yloc_stg_q <= wdata[YW-1:0];
    end
  end

  // Sticky overflow: a dropped push beats the read-to-clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (flush)       overflow_d = 1'b0;
    else if (drop)   overflow_d = 1'b1;
    else if (rd_hit) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  // Status read mux; zero unless the status address is being read.
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      rdata[STAT_OVF_BIT]   = overflow_q;
      rdata[STAT_FULL_BIT]  = fifo_full;
      rdata[STAT_EMPTY_BIT] = fifo_empty;
      rdata[CNT_W-1:0]      = fifo_count;
    end
  end

endmodule

// File: tb/tb_bmp_cmd_queue.sv
module tb_bmp_cmd_queue;
  import bmp_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        rd_hit;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [9:0]  cmd_xloc;
  logic [8:0]  cmd_yloc;
  logic [5:0]  cmd_img;

  int vectors = 0;
  int miscompares = 0;

  bmp_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mm_we     (mm_we),
    .mm_re     (mm_re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rd_hit    (rd_hit),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_xloc  (cmd_xloc),
    .cmd_yloc  (cmd_yloc),
    .cmd_img   (cmd_img)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of commands, sticky overflow, staged X/Y.
  bmp_cmd_t   mq[$];
  logic       m_ovf = 1'b0;
  logic [9:0] m_x = '0;
  logic [8:0] m_y = '0;

  always @(posedge clk or negedge rst_n) begin
    bit m_pop, m_push, m_flush, m_hit, m_drop;
    bmp_cmd_t e;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_x = '0;
      m_y = '0;
    end else begin
      m_pop   = (mq.size() != 0) && cmd_ready;
      m_push  = mm_we && (addr == 16'hC00A);
      m_flush = mm_we && (addr == 16'hC00B) && wdata[0];
      m_hit   = mm_re && (addr == 16'hC00B);
      m_drop  = 1'b0;
      if (m_flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (m_push && mq.size() == DEPTH && !m_pop) m_drop = 1'b1;
        if (m_pop) void'(mq.pop_front());
        if (m_push && !m_drop) begin
          e.xloc = m_x;
          e.yloc = m_y;
          e.img  = wdata[5:0];
          mq.push_back(e);
        end
        if (m_drop) m_ovf = 1'b1;
        else if (m_hit) m_ovf = 1'b0;
      end
      if (mm_we && addr == 16'hC008) m_x = wdata[9:0];
      if (mm_we && addr == 16'hC009) m_y = wdata[8:0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic        e_hit;
    logic [15:0] e_stat;
    e_hit  = mm_re && (addr == 16'hC00B);
    e_stat = '0;
    if (e_hit) begin
      e_stat[15] = m_ovf;
      e_stat[14] = (mq.size() == DEPTH);
      e_stat[13] = (mq.size() == 0);
      e_stat[CNT_W-1:0] = CNT_W'(mq.size());
    end
    check("model_cmd_valid", cmd_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("model_cmd_xloc", cmd_xloc, mq[0].xloc);
      check("model_cmd_yloc", cmd_yloc, mq[0].yloc);
      check("model_cmd_img", cmd_img, mq[0].img);
    end
    check("model_rd_hit", rd_hit, e_hit);
    check("model_rdata", rdata, e_stat);
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mm_we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    mm_we = 1'b0; addr = 16'h0; wdata = 16'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    mm_re = 1'b1; addr = a;
    @(negedge clk);
    check(name, rdata, exp);
    @(posedge clk); #1;
    mm_re = 1'b0; addr = 16'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_cmd_xloc", cmd_xloc, 10'd0);
    check("reset_cmd_yloc", cmd_yloc, 9'd0);
    check("reset_cmd_img", cmd_img, 6'd0);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_rd_hit", rd_hit, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single command, engine stalled.
    cmd_ready = 1'b0;
    wr(16'hC008, 16'h0140);
    wr(16'hC009, 16'h00F0);
    wr(16'hC00A, 16'h0005);
    @(negedge clk);
    check("t1_valid", cmd_valid, 1'b1);
    check("t1_xloc", cmd_xloc, 10'd320);
    check("t1_yloc", cmd_yloc, 9'd240);
    check("t1_img", cmd_img, 6'd5);
    @(posedge clk); #1;
    rd(16'hC00B, 16'h0001, "t1_status");
    rd(16'hC008, 16'h0000, "t1_wo_read");

    // Drain, then three pushes with the engine always ready.
    cmd_ready = 1'b1;
    idle(2);
    wr(16'hC008, 16'h0011);
    wr(16'hC009, 16'h0022);
    wr(16'hC00A, 16'h0001);
    wr(16'hC00A, 16'h0002);
    wr(16'hC00A, 16'h0003);
    idle(3);
    rd(16'hC00B, 16'h2000, "t2_status");

    // Overfill by one, then read-to-clear.
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(16'hC008, 16'(i * 16 + 1));
      wr(16'hC009, 16'(i * 8 + 2));
      wr(16'hC00A, 16'(i + 32));
    end
    rd(16'hC00B, 16'hC008, "t3_status_ovf");
    rd(16'hC00B, 16'h4008, "t3_status_clr");

    // Push and pop together while full.
    wr(16'hC008, 16'h03FF);
    wr(16'hC009, 16'h01FF);
    cmd_ready = 1'b1;
    wr(16'hC00A, 16'h003F);
    cmd_ready = 1'b0;
    rd(16'hC00B, 16'h4008, "t4_status_full");
    cmd_ready = 1'b1;
    idle(10);
    cmd_ready = 1'b0;
    rd(16'hC00B, 16'h2000, "t4_status_drained");

    // Ignored writes, then flush with the engine ready.
    for (int i = 0; i < 5; i++) wr(16'hC00A, 16'(i + 10));
    wr(16'hC00B, 16'h0000);
    wr(16'hC00C, 16'h0001);
    wr(16'h400A, 16'h0007);
    rd(16'hC00B, 16'h0005, "t5_status_pre");
    cmd_ready = 1'b1;
    wr(16'hC00B, 16'h0001);
    cmd_ready = 1'b0;
    @(negedge clk);
    check("t5_flush_valid", cmd_valid, 1'b0);
    @(posedge clk); #1;
    rd(16'hC00B, 16'h2000, "t5_status_post");

    // Asynchronous reset in the middle of a cycle with four queued.
    for (int i = 0; i < 4; i++) wr(16'hC00A, 16'(i + 20));
    #2 rst_n = 1'b0;
    #1 check("t6_async_valid", cmd_valid, 1'b0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    wr(16'hC00A, 16'h002A);
    @(negedge clk);
    check("t6_valid", cmd_valid, 1'b1);
    check("t6_xloc", cmd_xloc, 10'd0);
    check("t6_yloc", cmd_yloc, 9'd0);
    check("t6_img", cmd_img, 6'h2A);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    idle(2);
    cmd_ready = 1'b0;
    rd(16'hC00B, 16'h2000, "t6_status");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
